vga_fb_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM between two users: the VGA scanout, which reads, and a host writer.
- Framebuffer: 200x150 pixels (800x600 shown as 4x4 blocks), 4 bits per pixel, packed 4 pixels per 16-bit word, 7500 words.
- Scanout reads have absolute priority. Host writes go through a small FIFO and use free RAM cycles.
- A built-in clear engine fills the whole framebuffer with one word value.

---
 rtl/vga_fb_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout reads (absolute priority),
// a FIFO-buffered host writer and a whole-framebuffer clear engine.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FB_WORDS   = 7500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_host_valid,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  output logic              o_host_ready,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_clear_data,
  output logic              o_busy,
  output logic              o_addr_err,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] clr_data_q, clr_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_v1_q, rd_v1_d, rd_oob1_q, rd_oob1_d;
  logic              rd_v2_q, rd_v2_d, rd_oob2_q, rd_oob2_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              addr_err_q, addr_err_d;
  logic              busy_q, busy_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              host_ready, push, pop;

  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= i_host_addr;
      fifo_data_mem[wr_ptr_q] <= i_host_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    clr_data_d   = clr_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    addr_err_d   = 1'b0;
    rd_v1_d      = 1'b0;
    rd_oob1_d    = 1'b0;
    rd_v2_d      = rd_v1_q;
    rd_oob2_d    = rd_oob1_q;
    disp_valid_d = rd_v2_q;
    disp_data_d  = disp_data_q;
    if (rd_v2_q) disp_data_d = rd_oob2_q ? '0 : i_ram_rdata;

    // Hosts may not enqueue once a clear is requested, so DRAIN always terminates.
    host_ready = (state_q == ST_IDLE) && (count_q != FULL_CNT) && !i_clear;
    push       = i_host_valid && host_ready;
    pop        = 1'b0;

    if (i_disp_req) begin
      rd_v1_d = 1'b1;
      if (i_disp_addr >= LIMIT) begin
        rd_oob1_d  = 1'b1;
        addr_err_d = 1'b1;
      end else begin
        ram_en_d   = 1'b1;
        ram_addr_d = i_disp_addr;
      end
    end else if (state_q == ST_CLEAR) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = clr_ptr_q;
      ram_wdata_d = clr_data_q;
      clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == LAST_ADDR) state_d = ST_IDLE;
    end else if (count_q != '0) begin
      pop = 1'b1;
      if (fifo_addr_mem[rd_ptr_q] >= LIMIT) begin
        addr_err_d = 1'b1;
      end else begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = fifo_addr_mem[rd_ptr_q];
        ram_wdata_d = fifo_data_mem[rd_ptr_q];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          clr_data_d = i_clear_data;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          clr_ptr_d = '0;
          state_d   = ST_CLEAR;
        end
      end
      default: ;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      clr_ptr_q    <= '0;
      clr_data_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_v1_q      <= 1'b0;
      rd_oob1_q    <= 1'b0;
      rd_v2_q      <= 1'b0;
      rd_oob2_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      addr_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      clr_data_q   <= clr_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_v1_q      <= rd_v1_d;
      rd_oob1_q    <= rd_oob1_d;
      rd_v2_q      <= rd_v2_d;
      rd_oob2_q    <= rd_oob2_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      addr_err_q   <= addr_err_d;
      busy_q       <= busy_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign o_host_ready = host_ready;
  assign o_disp_valid = disp_valid_q;
  assign o_disp_data  = disp_data_q;
  assign o_addr_err   = addr_err_q;
  assign o_busy       = busy_q;
  assign o_ram_en     = ram_en_q;
  assign o_ram_we     = ram_we_q;
  assign o_ram_addr   = ram_addr_q;
  assign o_ram_wdata  = ram_wdata_q;

endmodule
